// File: rtl/nibble_serial_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_pkg
// Shared definitions for the nibble-serial adder controller and its 4-bit
// carry-lookahead slice.
//   state_t : controller states (IDLE, RUN, DONE)
//   NIB_W   : width of one adder slice in bits
// ---------------------------------------------------------------------------
package nibble_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

endpackage : nibble_serial_pkg

// File: rtl/nibble_serial_adder_ctrl_cla4.sv
// ---------------------------------------------------------------------------
// cla4
// Combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry into bit 0
//   s     : 4-bit sum
//   cout  : carry out of bit 3
// ---------------------------------------------------------------------------
module cla4
    import nibble_serial_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products of g/p/cin, so no carry ripples
    // through another carry term.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule : cla4

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Runs a WIDTH-bit add/subtract through a single shared cla4 slice, one
// nibble per cycle, LSB nibble first. The inter-nibble carry lives in one
// flip-flop. Valid/ready handshake on both the request and result sides.
// Parameters:
//   WIDTH : operand/result width, a multiple of 4 and at least 4
// Ports:
//   CLK, RST            : clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  : request handshake; A/B/CIN/SUB sampled on accept
//   A, B                : operands
//   CIN                 : carry-in (ignored when SUB=1)
//   SUB                 : 1 = A-B
//   out_valid, out_ready: result handshake
//   SUM, COUT, OVF      : result, MSB carry-out, two's-complement overflow
// Timing: accept at edge k, out_valid high from the cycle after edge k+NIB.
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t state;
    state_t state_next;

    // Operands and result held as nibble arrays so the slice index selects
    // a whole nibble directly.
    logic [NIB-1:0][NIB_W-1:0] opa;
    logic [NIB-1:0][NIB_W-1:0] opb;
    logic [NIB-1:0][NIB_W-1:0] sum_q;
    logic [IDX_W-1:0]          idx;
    logic                      carry;

    logic [NIB_W-1:0] slice_s;
    logic             slice_c;
    logic             accept;
    logic             step;
    logic             last;

    cla4 u_cla4 (
        .a    (opa[idx]),
        .b    (opb[idx]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    assign last = (idx == IDX_LAST);
    assign SUM  = sum_q;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // ---------------- FSM: next state and outputs ----------------
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            opa   <= '0;
            opb   <= '0;
            sum_q <= '0;
            idx   <= '0;
            carry <= 1'b0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry flop.
            opa   <= A;
            opb   <= SUB ? ~B : B;
            carry <= SUB | CIN;
            idx   <= '0;
            sum_q <= '0;
        end else if (step) begin
            sum_q[idx] <= slice_s;
            carry      <= slice_c;
            if (last) begin
                COUT <= slice_c;
                OVF  <= (opa[NIB-1][NIB_W-1] == opb[NIB-1][NIB_W-1]) &&
                        (slice_s[NIB_W-1] != opa[NIB-1][NIB_W-1]);
            end else begin
                // Holds at the last nibble rather than wrapping.
                idx <= idx + 1'b1;
            end
        end
    end

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16 with hand-computed
// expected values. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;

    int total  = 0;
    int passed = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .SUB       (SUB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operation at a falling edge, waits (bounded) for out_valid
    // and checks latency and result. Leaves the DUT in DONE at a falling edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int cnt;
        A        = a;
        B        = b;
        CIN      = cin;
        SUB      = sub;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge CLK);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge CLK);
            cnt++;
            // Scramble inputs once accepted; latched operands must be unaffected.
            in_valid = 1'b0;
            A        = ~a;
            B        = ~b;
            CIN      = ~cin;
            SUB      = ~sub;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(NIB + 1));
        check({tag, "_sum"},  32'(SUM),  32'(exp_sum));
        check({tag, "_cout"}, 32'(COUT), 32'(exp_cout));
        check({tag, "_ovf"},  32'(OVF),  32'(exp_ovf));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    // With out_ready high, checks that DONE lasts one cycle and SUM holds.
    task automatic release_op(input string tag, input logic [15:0] exp_sum);
        out_ready = 1'b1;
        @(negedge CLK);
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"},    32'(in_ready),  32'd1);
        check({tag, "_hold"},    32'(SUM),       32'(exp_sum));
    endtask

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        CIN       = 1'b0;
        SUB       = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(SUM),       32'd0);
        check("rst_cout",      32'(COUT),      32'd0);
        check("rst_ovf",       32'(OVF),       32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Basic add, no carries between nibbles.
        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        release_op("add_basic", 16'h5555);

        // Carry ripples through every nibble via the carry flop.
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        release_op("add_ripple", 16'h0000);

        // Positive overflow, then negative overflow with carry-out.
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        release_op("ovf_pos", 16'h8000);
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        release_op("ovf_neg", 16'h0000);

        // Carry-in honoured on add.
        run_op("add_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
        release_op("add_cin", 16'h0010);

        // Subtract with borrow (CIN ignored), then without borrow.
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        release_op("sub_borrow", 16'hFFFE);
        run_op("sub_nobrw", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        release_op("sub_nobrw", 16'h0002);

        // Back-pressure: result held for 3 cycles, new requests refused.
        out_ready = 1'b0;
        run_op("bp", 16'h9000, 16'h8001, 1'b0, 1'b0, 16'h1001, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A        = 16'h0101;
            B        = 16'h0202;
            @(negedge CLK);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_sum",       32'(SUM),       32'h1001);
            check("bp_cout",      32'(COUT),      32'd1);
            check("bp_ovf",       32'(OVF),       32'd1);
        end
        in_valid  = 1'b0;
        release_op("bp", 16'h1001);
        run_op("bp_next", 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
        release_op("bp_next", 16'h0303);

        // Leave a nonzero COUT/OVF behind so the reset checks below can fail.
        run_op("pre_rst", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        release_op("pre_rst", 16'h0000);

        // Reset in the middle of RUN, at idx=2.
        A        = 16'hFFFF;
        B        = 16'h0001;
        CIN      = 1'b0;
        SUB      = 1'b0;
        in_valid = 1'b1;
        @(posedge CLK);           // accept edge k
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);           // after edge k+1
        @(negedge CLK);           // after edge k+2: idx = 2
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",       32'(SUM),       32'd0);
        check("mid_rst_cout",      32'(COUT),      32'd0);
        check("mid_rst_ovf",       32'(OVF),       32'd0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < NIB + 3; i++) begin
                @(negedge CLK);
                if (out_valid) seen = 1'b1;
            end
            check("mid_rst_no_valid", 32'(seen), 32'd0);
        end
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        release_op("post_rst", 16'h0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule : tb_nibble_serial_adder_ctrl
